// File: rtl/axi_burst_mem_slave.sv
// AXI burst memory slave: DEPTH-word RAM behind independent AW/W/B and AR/R engines.
// Supports FIXED/INCR/WRAP bursts with byte strobes; out-of-range beats get SLVERR.

module axi_burst_mem_slave #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int DEPTH  = 256
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ID_W-1:0]       awid,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [LEN_W-1:0]      awlen,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_W-1:0]       arid,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [LEN_W-1:0]      arlen,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;
    localparam logic [1:0] B_WRAP  = 2'b10;
    localparam logic [1:0] R_OKAY  = 2'b00;
    localparam logic [1:0] R_SLV   = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    // Reserved burst type, or WRAP whose beat count is not 2/4/8/16.
    function automatic logic burst_bad(input logic [LEN_W-1:0] len,
                                       input logic [1:0] burst);
        int unsigned n;
        n = 32'(len) + 1;
        burst_bad = (burst == 2'b11) ||
                    ((burst == B_WRAP) &&
                     ((n < 2) || (n > 16) || ((n & (n - 1)) != 0)));
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [LEN_W-1:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] m;
        m = ((ADDR_W'(len) + ADDR_W'(1)) << OFF) - ADDR_W'(1);
        unique case (burst)
            B_FIXED: next_addr = a;
            B_WRAP:  next_addr = (a & ~m) | ((a + ADDR_W'(NB)) & m);
            default: next_addr = a + ADDR_W'(NB);
        endcase
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        in_range = ((a >> (OFF + IDX_W)) == '0);
    endfunction

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        align = a & ~ADDR_W'(NB - 1);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // Write engine state
    w_state_e           w_state_q, w_state_d;
    logic               awready_q, awready_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [ID_W-1:0]    bid_q, bid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [LEN_W-1:0]   wlen_q, wlen_d;
    logic [1:0]         wburst_q, wburst_d;
    logic [LEN_W-1:0]   wcnt_q, wcnt_d;
    logic               werr_q, werr_d;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_widx;

    // Read engine state
    r_state_e           r_state_q, r_state_d;
    logic               arready_q, arready_d;
    logic [ID_W-1:0]    rid_q, rid_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic [LEN_W-1:0]   rlen_q, rlen_d;
    logic [1:0]         rburst_q, rburst_d;
    logic               rerr_q, rerr_d;
    logic [LEN_W-1:0]   icnt_q, icnt_d;
    logic               idone_q, idone_d;
    logic               s1_v_q, s1_v_d;
    logic               s1_oor_q, s1_oor_d;
    logic [1:0]         s1_resp_q, s1_resp_d;
    logic               s1_last_q, s1_last_d;
    logic [DATA_W-1:0]  ram_rdata_q;
    logic               rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;
    logic               rlast_q, rlast_d;
    logic               s1_ld, s1_mv, r_hs;
    logic [IDX_W-1:0]   mem_ridx;

    // Write FSM: AW capture, strobed beat writes, B response
    always_comb begin
        logic wbad;
        logic wl_exp;
        logic woor;
        wbad      = 1'b0;
        wl_exp    = 1'b0;
        woor      = 1'b0;
        w_state_d = w_state_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        mem_we    = 1'b0;
        mem_widx  = waddr_q[OFF +: IDX_W];
        unique case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    wbad      = burst_bad(awlen, awburst);
                    bid_d     = awid;
                    waddr_d   = align(awaddr);
                    wlen_d    = awlen;
                    wburst_d  = wbad ? B_INCR : awburst;
                    wcnt_d    = '0;
                    werr_d    = wbad;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    wl_exp  = (wcnt_q == wlen_q);
                    woor    = !in_range(waddr_q);
                    mem_we  = !woor;
                    werr_d  = werr_q | woor | (wlast != wl_exp);
                    waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
                    wcnt_d  = wcnt_q + 1'b1;
                    if (wl_exp) begin
                        bresp_d   = werr_d ? R_SLV : R_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready && bvalid_q) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Write FSM registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
        end
    end

    // Read FSM: AR capture, RAM fetch stage, output stage held under stall
    always_comb begin
        logic rbad;
        rbad      = 1'b0;
        r_state_d = r_state_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rerr_d    = rerr_q;
        icnt_d    = icnt_q;
        idone_d   = idone_q;
        s1_v_d    = s1_v_q;
        s1_oor_d  = s1_oor_q;
        s1_resp_d = s1_resp_q;
        s1_last_d = s1_last_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        mem_ridx  = raddr_q[OFF +: IDX_W];
        r_hs      = rvalid_q && rready;
        s1_mv     = s1_v_q && (!rvalid_q || rready);
        s1_ld     = (r_state_q == R_DATA) && !idone_q && (!s1_v_q || s1_mv);
        unique case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    rbad      = burst_bad(arlen, arburst);
                    rid_d     = arid;
                    raddr_d   = align(araddr);
                    rlen_d    = arlen;
                    rburst_d  = rbad ? B_INCR : arburst;
                    rerr_d    = rbad;
                    icnt_d    = '0;
                    idone_d   = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs && rlast_q) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (s1_ld) begin
            s1_v_d    = 1'b1;
            s1_oor_d  = !in_range(raddr_q);
            s1_resp_d = (rerr_q || !in_range(raddr_q)) ? R_SLV : R_OKAY;
            s1_last_d = (icnt_q == rlen_q);
            raddr_d   = next_addr(raddr_q, rlen_q, rburst_q);
            if (icnt_q == rlen_q) begin
                idone_d = 1'b1;
            end else begin
                icnt_d = icnt_q + 1'b1;
            end
        end else if (s1_mv) begin
            s1_v_d = 1'b0;
        end
        if (s1_mv) begin
            rvalid_d = 1'b1;
            rdata_d  = s1_oor_q ? '0 : ram_rdata_q;
            rresp_d  = s1_resp_q;
            rlast_d  = s1_last_q;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
        end
        arready_d = (r_state_d == R_IDLE);
    end

    // Read FSM registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rburst_q  <= '0;
            rerr_q    <= 1'b0;
            icnt_q    <= '0;
            idone_q   <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_oor_q  <= 1'b0;
            s1_resp_q <= '0;
            s1_last_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rerr_q    <= rerr_d;
            icnt_q    <= icnt_d;
            idone_q   <= idone_d;
            s1_v_q    <= s1_v_d;
            s1_oor_q  <= s1_oor_d;
            s1_resp_q <= s1_resp_d;
            s1_last_q <= s1_last_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // RAM: strobed write port, registered read port (reads see pre-write data)
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    mem[mem_widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (s1_ld) begin
            ram_rdata_q <= mem[mem_ridx];
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rid     = rid_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Testbench for axi_burst_mem_slave: directed plus randomized bursts
// checked against a byte-level memory model with arithmetic address rules.

module tb_axi_burst_mem_slave;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int DEPTH  = 256;

    logic              aclk;
    logic              aresetn;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    axi_burst_mem_slave #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .LEN_W(LEN_W), .DEPTH(DEPTH)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] dq [$];
    logic [3:0]  sq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return awready;
            1: return wready;
            2: return bvalid;
            3: return arready;
            4: return rvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int w, input string tag, output int n);
        n = 0;
        while (sig(w) !== 1'b1 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 200) chk({tag, "_timeout"}, 64'(sig(w)), 64'(1));
    endtask

    function automatic bit is_bad(input int len, input logic [1:0] burst);
        return (burst == 2'b11) ||
               (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    // Byte address of beat i, straight from the burst rules.
    function automatic int unsigned beat_addr(input int unsigned start, input int len,
                                              input logic [1:0] burst, input int i);
        int unsigned a, size, base;
        a = start & ~32'h3;
        if (is_bad(len, burst) || burst == 2'b01) return a + 4 * i;
        if (burst == 2'b00) return a;
        size = (len + 1) * 4;
        base = (a / size) * size;
        return base + ((a - base) + 4 * i) % size;
    endfunction

    task automatic axi_write(input logic [3:0] id, input int unsigned addr, input int len,
                             input logic [1:0] burst, input logic [31:0] data[$],
                             input logic [3:0] strb[$], input int badlast, input bit gaps,
                             output logic [1:0] resp);
        bit err;
        int n, g;
        int unsigned a;
        err = is_bad(len, burst);
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, burst, i);
            if ((a >> 2) >= DEPTH) err = 1'b1;
            else for (int b = 0; b < 4; b++)
                if (strb[i][b]) model[a >> 2][b*8 +: 8] = data[i][b*8 +: 8];
            if (i == badlast) err = 1'b1;
        end
        awid = id; awaddr = addr; awlen = 4'(len); awburst = burst; awvalid = 1'b1;
        wait_for(0, "awready", n);
        @(negedge aclk);
        awvalid = 1'b0;
        chk("w_rdy_lat", 64'(wready), 64'(1));
        for (int i = 0; i <= len; i++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            if (g > 0) begin
                wvalid = 1'b0;
                repeat (g) @(negedge aclk);
            end
            wvalid = 1'b1; wdata = data[i]; wstrb = strb[i];
            wlast = (i == len) ^ (i == badlast);
            wait_for(1, "wready", n);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("b_lat", 64'(bvalid), 64'(1));
        if (gaps) repeat ($urandom_range(0, 3)) begin
            @(negedge aclk);
            chk("b_hold", 64'(bvalid), 64'(1));
        end
        chk("bid", 64'(bid), 64'(id));
        chk("bresp", 64'(bresp), 64'(err ? 2 : 0));
        resp = bresp;
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("b_drop", 64'(bvalid), 64'(0));
    endtask

    task automatic axi_read(input logic [3:0] id, input int unsigned addr, input int len,
                            input logic [1:0] burst, input bit stalls, input bit lat,
                            output logic [31:0] last_data);
        int n;
        int unsigned a;
        bit oor;
        logic [31:0] ed;
        logic [35:0] snap;
        arid = id; araddr = addr; arlen = 4'(len); arburst = burst; arvalid = 1'b1;
        wait_for(3, "arready", n);
        @(negedge aclk);
        arvalid = 1'b0;
        if (lat) begin
            chk("r_lat0", 64'(rvalid), 64'(0));
            @(negedge aclk);
            chk("r_lat1", 64'(rvalid), 64'(0));
            @(negedge aclk);
            chk("r_lat2", 64'(rvalid), 64'(1));
        end
        if (!stalls) rready = 1'b1;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, burst, i);
            oor = (a >> 2) >= DEPTH;
            ed = oor ? 32'h0 : model[a >> 2];
            wait_for(4, "rvalid", n);
            if (!stalls && i > 0) chk("r_b2b", 64'(n), 64'(0));
            if (stalls) begin
                snap = {rvalid, rlast, rresp, rdata};
                repeat ($urandom_range(0, 3)) begin
                    @(negedge aclk);
                    chk("r_stable", 64'({rvalid, rlast, rresp, rdata}), 64'(snap));
                end
                rready = 1'b1;
            end
            chk("rdata", 64'(rdata), 64'(ed));
            chk("rresp", 64'(rresp), 64'((oor || is_bad(len, burst)) ? 2 : 0));
            chk("rlast", 64'(rlast), 64'(i == len));
            chk("rid", 64'(rid), 64'(id));
            chk("ar_busy", 64'(arready), 64'(0));
            last_data = rdata;
            @(negedge aclk);
            if (stalls) rready = 1'b0;
        end
        rready = 1'b0;
        chk("ar_back", 64'(arready), 64'(1));
    endtask

    task automatic fill_q(input int len, input bit rnd_strb);
        dq = {};
        sq = {};
        for (int i = 0; i <= len; i++) begin
            dq.push_back($urandom);
            sq.push_back(rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF);
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd, d0, d3;
        int n, len;
        int unsigned addr;
        logic [1:0] bt;

        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge aclk);

        chk("rst_awready", 64'(awready), 64'(0));
        chk("rst_wready", 64'(wready), 64'(0));
        chk("rst_bvalid", 64'(bvalid), 64'(0));
        chk("rst_arready", 64'(arready), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_rlast", 64'(rlast), 64'(0));
        chk("rst_bid_bresp", 64'({bid, bresp}), 64'(0));
        chk("rst_rid_rresp", 64'({rid, rresp}), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));

        aresetn = 1'b1;
        #1;
        chk("aw_rdy_pre", 64'(awready), 64'(0));
        @(negedge aclk);
        chk("aw_rdy_post", 64'(awready), 64'(1));
        chk("ar_rdy_post", 64'(arready), 64'(1));

        for (int blk = 0; blk < 16; blk++) begin
            fill_q(15, 1'b0);
            axi_write(4'(blk), 32'(blk * 64), 15, 2'b01, dq, sq, -1, 1'b0, resp);
        end

        fill_q(3, 1'b0);
        for (int i = 0; i < 4; i++) dq[i] = 32'hA0 + 32'(i);
        axi_write(4'h3, 32'h10, 3, 2'b01, dq, sq, -1, 1'b0, resp);
        axi_read(4'h7, 32'h10, 3, 2'b01, 1'b0, 1'b1, rd);

        axi_read(4'h2, 32'h38, 3, 2'b10, 1'b0, 1'b1, rd);

        fill_q(0, 1'b0);
        dq[0] = 32'h0;
        axi_write(4'h1, 32'h20, 0, 2'b01, dq, sq, -1, 1'b0, resp);
        fill_q(3, 1'b0);
        sq[0] = 4'h1; sq[1] = 4'h2; sq[2] = 4'h2; sq[3] = 4'h2;
        d0 = dq[0]; d3 = dq[3];
        axi_write(4'h4, 32'h20, 3, 2'b00, dq, sq, -1, 1'b1, resp);
        axi_read(4'h4, 32'h20, 0, 2'b01, 1'b0, 1'b0, rd);
        chk("fixed_word", 64'(rd), 64'({16'h0, d3[15:8], d0[7:0]}));

        fill_q(3, 1'b0);
        axi_write(4'h6, 32'h3F8, 3, 2'b01, dq, sq, -1, 1'b0, resp);
        chk("oob_bresp", 64'(resp), 64'(2));
        axi_read(4'h6, 32'h3F8, 3, 2'b01, 1'b1, 1'b0, rd);
        chk("oob_rdata", 64'(rd), 64'(0));
        axi_read(4'h6, 32'h0, 1, 2'b01, 1'b0, 1'b0, rd);

        fill_q(2, 1'b0);
        axi_write(4'h8, 32'h40, 2, 2'b10, dq, sq, -1, 1'b0, resp);
        axi_read(4'h8, 32'h40, 2, 2'b11, 1'b0, 1'b0, rd);
        fill_q(3, 1'b0);
        axi_write(4'hA, 32'h60, 3, 2'b01, dq, sq, 1, 1'b0, resp);
        fill_q(7, 1'b1);
        axi_write(4'hB, 32'h1E8, 7, 2'b10, dq, sq, -1, 1'b1, resp);
        axi_read(4'hB, 32'h1F0, 7, 2'b10, 1'b1, 1'b0, rd);

        fill_q(15, 1'b1);
        fork
            axi_write(4'h9, 32'h100, 15, 2'b01, dq, sq, -1, 1'b1, resp);
            axi_read(4'h5, 32'h200, 15, 2'b01, 1'b1, 1'b1, rd);
        join
        axi_read(4'h9, 32'h100, 15, 2'b01, 1'b0, 1'b0, rd);

        for (int it = 0; it < 12; it++) begin
            len = int'($urandom_range(0, 15));
            bt = 2'($urandom_range(0, 3));
            addr = $urandom_range(0, 255) * 4;
            fill_q(len, 1'b1);
            axi_write(4'($urandom_range(0, 15)), addr, len, bt, dq, sq, -1, 1'($urandom), resp);
            axi_read(4'($urandom_range(0, 15)), addr, len, bt, 1'($urandom), 1'b0, rd);
        end

        fill_q(7, 1'b0);
        awid = 4'h5; awaddr = 32'h80; awlen = 4'd7; awburst = 2'b01; awvalid = 1'b1;
        wait_for(0, "awready", n);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = dq[i]; wstrb = 4'hF; wlast = 1'b0;
            wait_for(1, "wready", n);
            @(negedge aclk);
            model[(32'h80 >> 2) + i] = dq[i];
        end
        wdata = dq[2];
        aresetn = 1'b0;
        #1;
        chk("rst_mid_bvalid", 64'(bvalid), 64'(0));
        chk("rst_mid_wready", 64'(wready), 64'(0));
        wvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("rst_rel_aw_pre", 64'(awready), 64'(0));
        @(negedge aclk);
        chk("rst_rel_aw", 64'(awready), 64'(1));
        chk("rst_rel_bvalid", 64'(bvalid), 64'(0));
        fill_q(3, 1'b0);
        axi_write(4'h6, 32'h80, 3, 2'b01, dq, sq, -1, 1'b0, resp);
        chk("rst_clean_bresp", 64'(resp), 64'(0));
        axi_read(4'h6, 32'h80, 7, 2'b01, 1'b0, 1'b1, rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
